kb_scan_decoder: RTL and testbench

Sits between ps2_rx and the display/game engine. Consumes raw scan-code bytes (rx_done_tick + dout), tracks the E0/F0 prefix protocol, and maintains a held-key bitmap for the six game keys (A/D/W/S/R/Enter). Emits one-cycle press pulses and buffers every decoded make/break event in a small FIFO with valid/ready handshake. Replaces the six parallel single-key matchers.

---
 rtl/kb_scan_decoder_pkg.sv | 62 ++++++
 rtl/kb_scan_decoder_if.sv | 33 +++
 rtl/kb_scan_decoder_event_fifo.sv | 61 ++++++
 rtl/kb_scan_decoder.sv | 187 ++++++++++++++++++
 tb/tb_kb_scan_decoder.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kb_scan_decoder_pkg.sv
// kb_pkg: shared constants and types for the keyboard scan-code decoder.
// Scan-code prefixes, game-key indices, make-code maps, FSM states and the
// event record stored in the event FIFO.
package kb_pkg;

  // Prefix bytes of the PS/2 set-2 protocol
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Game key indices into key_held / key_press_tick
  localparam int KEY_LEFT       = 0;
  localparam int KEY_RIGHT      = 1;
  localparam int KEY_UP         = 2;
  localparam int KEY_DOWN       = 3;
  localparam int KEY_GAME_RESET = 4;
  localparam int KEY_ENTER      = 5;
  localparam int NUM_KEYS       = 6;
  localparam int NUM_ARROWS     = 4;

  // Plain (non-extended) make codes of the game keys
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Extended (E0-prefixed) arrow-key make codes
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;

  // Code maps packed so that byte k holds the code of key index k
  localparam logic [NUM_KEYS*8-1:0] BASE_MAP =
    {SC_ENTER, SC_R, SC_S, SC_W, SC_D, SC_A};
  localparam logic [NUM_ARROWS*8-1:0] ARROW_MAP =
    {SC_ARROW_DOWN, SC_ARROW_UP, SC_ARROW_RIGHT, SC_ARROW_LEFT};

  // Prefix tracker: which prefix bytes have been seen for the pending code
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_t;

  // One decoded make/break event
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kb_event_t;

  localparam int EVENT_W = $bits(kb_event_t);

  // True for either prefix byte
  function automatic logic is_prefix(input logic [7:0] code);
    return (code == SC_EXT) || (code == SC_BRK);
  endfunction

endpackage

// File: rtl/kb_scan_decoder_if.sv
// kb_scan_decoder_if: scan-byte input strobe plus the valid/ready event
// stream. master = producer of bytes / consumer of events, slave = decoder.
interface kb_scan_decoder_if;

  logic       scan_done_tick;
  logic [7:0] scan_code;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;

  modport master (
    output scan_done_tick,
    output scan_code,
    output ev_ready,
    input  ev_valid,
    input  ev_code,
    input  ev_break,
    input  ev_ext
  );

  modport slave (
    input  scan_done_tick,
    input  scan_code,
    input  ev_ready,
    output ev_valid,
    output ev_code,
    output ev_break,
    output ev_ext
  );

endinterface

// File: rtl/kb_scan_decoder_event_fifo.sv
// kb_event_fifo: small synchronous FIFO with combinational head read.
// A push into a full FIFO is accepted only if a pop happens in the same
// cycle; pops on an empty FIFO are ignored. DEPTH must be a power of two.
module kb_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/kb_scan_decoder.sv
// kb_scan_decoder: turns raw PS/2 scan bytes into make/break events.
// Tracks the E0/F0 prefixes with a small FSM (with a prefix timeout),
// keeps a held bitmap for six game keys, pulses key_press_tick on a key's
// first make, and queues every decoded event in kb_event_fifo.
// Build option: define KB_EXT_KEYS_EN to let the E0 arrow keys drive the
// same held bits as WASD; otherwise extended events only reach the FIFO.
module kb_scan_decoder
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                clk,
  input  logic                reset,
  kb_scan_decoder_if.slave    bus,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press_tick,
  output logic                ev_overflow
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  kb_state_t           state_reg;
  kb_state_t           state_next;
  logic [TMO_W-1:0]    tmo_cnt_reg;
  logic                timeout_hit;

  logic                emit_valid;
  kb_event_t           emit_ev;

  logic [NUM_KEYS-1:0] base_hit;
  logic [NUM_KEYS-1:0] key_hit;
  logic [NUM_KEYS-1:0] key_held_reg;
  logic [NUM_KEYS-1:0] key_held_next;
  logic [NUM_KEYS-1:0] key_press_reg;
  logic [NUM_KEYS-1:0] key_press_next;
  logic                ev_overflow_reg;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [EVENT_W-1:0]  fifo_dout;
  kb_event_t           head_ev;

  // A prefix left dangling for too long is abandoned
  assign timeout_hit = (state_reg != ST_IDLE) && (tmo_cnt_reg == TMO_LAST);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: bytes advance the prefix tracker, a timeout drops it
  always_comb begin
    state_next = state_reg;
    if (bus.scan_done_tick) begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.scan_code == SC_EXT)      state_next = ST_EXT;
          else if (bus.scan_code == SC_BRK) state_next = ST_BRK;
          else                              state_next = ST_IDLE;
        end
        ST_EXT: begin
          if (bus.scan_code == SC_BRK)      state_next = ST_EXT_BRK;
          else if (bus.scan_code == SC_EXT) state_next = ST_EXT;
          else                              state_next = ST_IDLE;
        end
        // After F0 any byte ends the sequence; a prefix here is discarded
        default:                            state_next = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = ST_IDLE;
    end
  end

  // FSM outputs: a non-prefix byte completes an event tagged by the state
  always_comb begin
    emit_valid   = 1'b0;
    emit_ev      = '0;
    emit_ev.code = bus.scan_code;
    if (bus.scan_done_tick && !is_prefix(bus.scan_code)) begin
      emit_valid  = 1'b1;
      emit_ev.ext = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
      emit_ev.brk = (state_reg == ST_BRK) || (state_reg == ST_EXT_BRK);
    end
  end

  // Prefix timeout counter: restarts on every byte, runs only mid-prefix
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_reg <= '0;
    end else if (bus.scan_done_tick || (state_reg == ST_IDLE) || timeout_hit) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  // Plain make-code matchers, one per game key
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_base_hit
      assign base_hit[gi] = (bus.scan_code == BASE_MAP[gi*8 +: 8]);
    end
  endgenerate

`ifdef KB_EXT_KEYS_EN
  logic [NUM_ARROWS-1:0] arrow_hit;

  // Arrow matchers share the held bits of the matching WASD keys
  generate
    for (genvar gi = 0; gi < NUM_ARROWS; gi++) begin : g_arrow_hit
      assign arrow_hit[gi] = (bus.scan_code == ARROW_MAP[gi*8 +: 8]);
    end
  endgenerate

  // Key selection: extended events map through the arrow table
  always_comb begin
    key_hit = emit_ev.ext ? {{(NUM_KEYS-NUM_ARROWS){1'b0}}, arrow_hit} : base_hit;
  end
`else
  // Key selection: extended events never touch the held bitmap
  always_comb begin
    key_hit = emit_ev.ext ? '0 : base_hit;
  end
`endif

  // Per-key held/press update; a repeat make of a held key gives no pulse
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      assign key_press_next[gi] = emit_valid && key_hit[gi] && !emit_ev.brk &&
                                  !key_held_reg[gi];
      assign key_held_next[gi]  = (emit_valid && key_hit[gi]) ? !emit_ev.brk
                                                              : key_held_reg[gi];
    end
  endgenerate

  // Held bitmap and press pulses, updated the cycle after the final byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_held_reg  <= '0;
      key_press_reg <= '0;
    end else begin
      key_held_reg  <= key_held_next;
      key_press_reg <= key_press_next;
    end
  end

  assign fifo_pop = bus.ev_ready && !fifo_empty;

  // Sticky overflow: an event arrived with the FIFO full and nothing leaving
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_overflow_reg <= 1'b0;
    end else if (emit_valid && fifo_full && !fifo_pop) begin
      ev_overflow_reg <= 1'b1;
    end
  end

  kb_event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (emit_valid),
    .din   (emit_ev),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_ev        = fifo_dout;
  assign bus.ev_valid   = !fifo_empty;
  assign bus.ev_code    = head_ev.code;
  assign bus.ev_break   = head_ev.brk;
  assign bus.ev_ext     = head_ev.ext;
  assign key_held       = key_held_reg;
  assign key_press_tick = key_press_reg;
  assign ev_overflow    = ev_overflow_reg;

endmodule

// File: tb/tb_kb_scan_decoder.sv
// tb_kb_scan_decoder: directed table, multi-cycle corner sequences and a
// randomized run, all compared every cycle against a behavioural model of
// the prefix protocol, key bitmap and event queue.
module tb_kb_scan_decoder;
  import kb_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
`ifdef KB_EXT_KEYS_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] key_held;
  logic [5:0] key_press_tick;
  logic       ev_overflow;

  always #5 clk = ~clk;

  kb_scan_decoder_if bus ();

  kb_scan_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .key_held       (key_held),
    .key_press_tick (key_press_tick),
    .ev_overflow    (ev_overflow)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit [5:0] m_held;
  bit [5:0] m_press;
  bit       m_ovf;
  bit [9:0] m_q[$];
  bit       m_ext_seen;
  bit       m_brk_seen;
  int       m_edge;
  int       m_last_tick;

  function automatic bit [5:0] m_keys(input bit ext, input bit [7:0] c);
    bit [5:0] k;
    k = '0;
    if (!ext) begin
      case (c)
        8'h1C: k = 6'b000001;
        8'h23: k = 6'b000010;
        8'h1D: k = 6'b000100;
        8'h1B: k = 6'b001000;
        8'h2D: k = 6'b010000;
        8'h5A: k = 6'b100000;
        default: k = '0;
      endcase
    end else if (EXT_EN) begin
      case (c)
        8'h6B: k = 6'b000001;
        8'h74: k = 6'b000010;
        8'h75: k = 6'b000100;
        8'h72: k = 6'b001000;
        default: k = '0;
      endcase
    end
    return k;
  endfunction

  task automatic model_reset();
    m_held = '0; m_press = '0; m_ovf = 1'b0; m_q.delete();
    m_ext_seen = 1'b0; m_brk_seen = 1'b0; m_edge = 0; m_last_tick = 0;
  endtask

  // One clock edge of the model with the inputs present at that edge
  task automatic model_edge(input bit t, input bit [7:0] c, input bit r);
    bit       emit, brk, ext, pop;
    bit [5:0] k;
    emit = 1'b0; brk = 1'b0; ext = 1'b0;
    pop = r && (m_q.size() != 0);
    if (t) begin
      // a prefix older than the timeout window has been forgotten
      if ((m_edge - m_last_tick) > TMO) begin
        m_ext_seen = 1'b0; m_brk_seen = 1'b0;
      end
      m_last_tick = m_edge;
      if (m_brk_seen) begin
        if (c != 8'hE0 && c != 8'hF0) begin
          emit = 1'b1; brk = 1'b1; ext = m_ext_seen;
        end
        m_ext_seen = 1'b0; m_brk_seen = 1'b0;
      end else if (c == 8'hF0) begin
        m_brk_seen = 1'b1;
      end else if (c == 8'hE0) begin
        m_ext_seen = 1'b1;
      end else begin
        emit = 1'b1; ext = m_ext_seen;
        m_ext_seen = 1'b0;
      end
    end
    m_press = '0;
    if (emit) begin
      k = m_keys(ext, c);
      if (brk) m_held = m_held & ~k;
      else begin
        m_press = k & ~m_held;
        m_held  = m_held | k;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (emit) begin
      if (m_q.size() < DEPTH) m_q.push_back({ext, brk, c});
      else m_ovf = 1'b1;
    end
    m_edge++;
  endtask

  // ---------------- drivers ----------------
  // Called at a falling edge; drives one cycle and compares at the next one
  task automatic step(input bit t, input bit [7:0] c, input bit r);
    bus.scan_done_tick = t;
    bus.scan_code      = c;
    bus.ev_ready       = r;
    model_edge(t, c, r);
    @(posedge clk);
    @(negedge clk);
    bus.scan_done_tick = 1'b0;
    chk("held", key_held, m_held);
    chk("press", key_press_tick, m_press);
    chk("valid", bus.ev_valid, m_q.size() != 0);
    chk("overflow", ev_overflow, m_ovf);
    if (m_q.size() != 0)
      chk("head", {bus.ev_ext, bus.ev_break, bus.ev_code}, m_q[0]);
    if (t)
      $display("byte %02h ready=%0d -> held=%b press=%b valid=%0d head=%0b_%0b_%02h ovf=%0d",
               c, r, key_held, key_press_tick, bus.ev_valid, bus.ev_ext,
               bus.ev_break, bus.ev_code, ev_overflow);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    bus.scan_done_tick = 1'b0;
    bus.ev_ready       = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", bus.ev_valid, 1'b0);
    chk("rst_overflow", ev_overflow, 1'b0);
    chk("rst_held", key_held, 6'b0);
    chk("rst_press", key_press_tick, 6'b0);
    model_edge(1'b0, 8'h00, 1'b0);
    @(negedge clk);
  endtask

  typedef struct {
    bit [7:0] code;
    bit [5:0] held;
    bit [5:0] press;
    bit       valid;
    bit [9:0] head;
  } vec_t;

  vec_t     tbl[17];
  bit [7:0] fill_codes[5];
  bit [7:0] pool[13];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit 500000 reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit [5:0] xk;
    xk = EXT_EN ? 6'b000001 : 6'b000000;
    tbl[0]  = '{8'h1C, 6'b000001, 6'b000001, 1'b1, 10'h01C};
    tbl[1]  = '{8'hF0, 6'b000001, 6'b000000, 1'b0, 10'h000};
    tbl[2]  = '{8'h1C, 6'b000000, 6'b000000, 1'b1, 10'h11C};
    tbl[3]  = '{8'h5A, 6'b100000, 6'b100000, 1'b1, 10'h05A};
    tbl[4]  = '{8'h5A, 6'b100000, 6'b000000, 1'b1, 10'h05A};
    tbl[5]  = '{8'h5A, 6'b100000, 6'b000000, 1'b1, 10'h05A};
    tbl[6]  = '{8'hF0, 6'b100000, 6'b000000, 1'b0, 10'h000};
    tbl[7]  = '{8'h5A, 6'b000000, 6'b000000, 1'b1, 10'h15A};
    tbl[8]  = '{8'hE0, 6'b000000, 6'b000000, 1'b0, 10'h000};
    tbl[9]  = '{8'h6B, xk,        xk,        1'b1, 10'h26B};
    tbl[10] = '{8'hE0, xk,        6'b000000, 1'b0, 10'h000};
    tbl[11] = '{8'hF0, xk,        6'b000000, 1'b0, 10'h000};
    tbl[12] = '{8'h6B, 6'b000000, 6'b000000, 1'b1, 10'h36B};
    tbl[13] = '{8'h22, 6'b000000, 6'b000000, 1'b1, 10'h022};
    tbl[14] = '{8'hF0, 6'b000000, 6'b000000, 1'b0, 10'h000};
    tbl[15] = '{8'hE0, 6'b000000, 6'b000000, 1'b0, 10'h000};
    tbl[16] = '{8'h23, 6'b000010, 6'b000010, 1'b1, 10'h023};
    fill_codes = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h2D};
    pool = '{8'hE0, 8'hF0, 8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h2D, 8'h5A,
             8'h6B, 8'h74, 8'h75, 8'h72, 8'h22};

    bus.scan_done_tick = 1'b0;
    bus.scan_code      = 8'h00;
    bus.ev_ready       = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Directed table: each byte checked, then its event (if any) popped
    for (int i = 0; i < 17; i++) begin
      step(1'b1, tbl[i].code, 1'b0);
      chk($sformatf("tbl%0d_held", i), key_held, tbl[i].held);
      chk($sformatf("tbl%0d_press", i), key_press_tick, tbl[i].press);
      chk($sformatf("tbl%0d_valid", i), bus.ev_valid, tbl[i].valid);
      if (tbl[i].valid)
        chk($sformatf("tbl%0d_head", i), {bus.ev_ext, bus.ev_break, bus.ev_code}, tbl[i].head);
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("tbl%0d_drained", i), bus.ev_valid, 1'b0);
      chk($sformatf("tbl%0d_pulse_once", i), key_press_tick, 6'b0);
    end

    // Overflow: five makes into a four-entry FIFO with no consumer
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, fill_codes[i], 1'b0);
      chk($sformatf("ovf_flag_%0d", i), ev_overflow, (i == 4) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_pop_order_%0d", i), {bus.ev_ext, bus.ev_break, bus.ev_code},
          {2'b00, fill_codes[i]});
      step(1'b0, 8'h00, 1'b1);
    end
    chk("ovf_empty_after_drain", bus.ev_valid, 1'b0);
    chk("ovf_sticky", ev_overflow, 1'b1);

    // Push while full with a same-cycle pop is accepted
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, fill_codes[i], 1'b0);
    step(1'b1, 8'h5A, 1'b1);
    chk("full_pushpop_no_ovf", ev_overflow, 1'b0);
    chk("full_pushpop_head", bus.ev_code, fill_codes[1]);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_pushpop_order_%0d", i), bus.ev_code,
          (i == 3) ? 8'h5A : fill_codes[i+1]);
      step(1'b0, 8'h00, 1'b1);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("pop_empty_ignored", bus.ev_valid, 1'b0);

    // Prefix still honoured at the last cycle of the window
    do_reset();
    step(1'b1, 8'hE0, 1'b0);
    repeat (TMO - 1) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h6B, 1'b0);
    chk("tmo_edge_ext_kept", {bus.ev_ext, bus.ev_break, bus.ev_code}, 10'h26B);
    step(1'b0, 8'h00, 1'b1);
    // Prefix dropped once the window has expired
    step(1'b1, 8'hE0, 1'b0);
    repeat (TMO) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h1D, 1'b0);
    chk("tmo_prefix_dropped", {bus.ev_ext, bus.ev_break, bus.ev_code}, 10'h01D);
    chk("tmo_held_up", key_held[2], 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Reset between F0 and its follow-up byte
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, fill_codes[i], 1'b0);
    chk("pre_reset_ovf", ev_overflow, 1'b1);
    step(1'b1, 8'hF0, 1'b0);
    do_reset();
    step(1'b1, 8'h23, 1'b0);
    chk("post_reset_make_held", key_held, 6'b000010);
    chk("post_reset_make_press", key_press_tick, 6'b000010);
    chk("post_reset_head", {bus.ev_ext, bus.ev_break, bus.ev_code}, 10'h023);
    chk("post_reset_ovf", ev_overflow, 1'b0);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 500; n++) begin
      bit t, r;
      t = ($urandom_range(0, 99) < 40);
      r = ($urandom_range(0, 99) < 50);
      step(t, pool[$urandom_range(0, 12)], r);
      if ($urandom_range(0, 49) == 0) begin
        int gap;
        gap = TMO - 1 + int'($urandom_range(0, 3));
        repeat (gap) step(1'b0, 8'h00, ($urandom_range(0, 1) == 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
